// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//   DATA_BITS     : payload bits per frame
//   OS_LO / OS_HI : the two supported oversampling ratios
//   rx_state_e    : receiver FSM state encoding
//   os_legal()    : true for a supported oversampling ratio
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int OS_LO     = 8;
  localparam int OS_HI     = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic bit os_legal(int os);
    return (os == OS_LO) || (os == OS_HI);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- serial line in, received byte and line status out.
//   rxd            : async serial line, idle high
//   rx_data_ready  : 1-clk pulse, rx_data holds a new byte
//   rx_data        : last correctly framed byte
//   rx_frame_error : 1-clk pulse, stop bit sampled low
//   rx_idle        : line high for >= 2*Oversampling ticks
//   rx_endofpacket : 1-clk pulse on rising rx_idle
// master = receiver side, slave = line driver / byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rxd;
  logic                 rx_data_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_error;
  logic                 rx_idle;
  logic                 rx_endofpacket;

  modport master (
    input  rxd,
    output rx_data_ready, rx_data, rx_frame_error, rx_idle, rx_endofpacket
  );

  modport slave (
    output rxd,
    input  rx_data_ready, rx_data, rx_frame_error, rx_idle, rx_endofpacket
  );

endinterface

// File: rtl/uart_rx_baudtickgen.sv
// BaudTickGen -- free-running fractional tick generator.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : run the accumulator (cleared while low)
//   tick       : 1-clk pulse at Baud*Oversampling
// Phase accumulator: the carry out of an ACC_W-bit adder is the tick, so
// the long-term rate is exact to within 2^-ACC_W of the clock.
module BaudTickGen #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int     ACC_W = 16;
  localparam longint INC_L = (((longint'(Baud) * longint'(Oversampling)) << ACC_W)
                              + longint'(ClkFrequency) / 2) / longint'(ClkFrequency);
  localparam logic [ACC_W:0] INC = INC_L[ACC_W:0];

  logic [ACC_W:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n)      acc <= '0;
    else if (enable) acc <= {1'b0, acc[ACC_W-1:0]} + INC;
    else             acc <= '0;
  end

  assign tick = acc[ACC_W];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with glitch filter and idle detection.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   rx    : uart_rx_if.master (rxd in; data, pulses and idle out)
// All outputs are registered. Everything after the synchroniser only
// advances on oversampling ticks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master rx
);

  // Unsupported ratios fall back to 8 so the counters stay well formed.
  localparam int OS    = os_legal(Oversampling) ? Oversampling : OS_LO;
  localparam int OS_W  = $clog2(OS);
  localparam int GAP_W = $clog2(2*OS) + 1;

  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS-1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OS/2-1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(2*OS);
  localparam logic [GAP_W-1:0] GAP_PRE = GAP_W'(2*OS-1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS-1);

  localparam logic [2:0] IDLE  = RX_IDLE;
  localparam logic [2:0] START = RX_START;
  localparam logic [2:0] DATA  = RX_DATA;
  localparam logic [2:0] STOP  = RX_STOP;
  localparam logic [2:0] BRK   = RX_BREAK;

  logic tick;

  BaudTickGen #(
    .ClkFrequency (ClkFrequency),
    .Baud         (Baud),
    .Oversampling (OS)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (1'b1),
    .tick   (tick)
  );

  // 2-FF synchroniser, reset to the idle level
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx.rxd};
  end

  // Saturating vote filter: rx_bit only flips once the counter hits a rail,
  // so a single-tick glitch never reaches the FSM.
  logic [1:0] flt_cnt;
  logic       rx_bit;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_cnt <= 2'd3;
      rx_bit  <= 1'b1;
    end else if (tick) begin
      if (sync[1] && flt_cnt != 2'd3)       flt_cnt <= flt_cnt + 1'b1;
      else if (!sync[1] && flt_cnt != 2'd0) flt_cnt <= flt_cnt - 1'b1;
      if (flt_cnt == 2'd3)      rx_bit <= 1'b1;
      else if (flt_cnt == 2'd0) rx_bit <= 1'b0;
    end
  end

  // Frame FSM
  logic [2:0]           state;
  logic [OS_W-1:0]      os_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic                 rdy_q, ferr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (!rx_bit) begin
            state  <= START;
            os_cnt <= '0;
          end
          // Re-check the start bit at its middle; a high line there is noise.
          START: if (os_cnt == OS_HALF) begin
            if (!rx_bit) begin
              state   <= DATA;
              os_cnt  <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
          // os_cnt wraps naturally; every wrap is one bit-centre sample.
          DATA: begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == OS_LAST) begin
              shreg   <= {rx_bit, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= STOP;
            end
          end
          STOP: begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == OS_LAST) begin
              if (rx_bit) begin
                data_q <= shreg;
                rdy_q  <= 1'b1;
                state  <= IDLE;
              end else begin
                ferr_q <= 1'b1;
                state  <= BRK;
              end
            end
          end
          // Held low line: wait for it to return high so only one error fires.
          BRK: if (rx_bit) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Gap counter; idle and end-of-packet are registered alongside it.
  logic [GAP_W-1:0] gap;
  logic             idle_q, eop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap    <= GAP_MAX;
      idle_q <= 1'b1;
      eop_q  <= 1'b0;
    end else begin
      eop_q <= 1'b0;
      if (tick) begin
        if (!rx_bit) begin
          gap    <= '0;
          idle_q <= 1'b0;
        end else if (gap != GAP_MAX) begin
          gap <= gap + 1'b1;
          if (gap == GAP_PRE) begin
            idle_q <= 1'b1;
            eop_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign rx.rx_data        = data_q;
  assign rx.rx_data_ready  = rdy_q;
  assign rx.rx_frame_error = ferr_q;
  assign rx.rx_idle        = idle_q;
  assign rx.rx_endofpacket = eop_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter ClkFrequency, default 50000000, system clock frequency in Hz.
REQ-002 Parameter Baud, default 115200, serial bit rate.
REQ-003 Parameter Oversampling, default 8, ticks per bit; legal values are 8 and 16 only.
REQ-004 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-006 Port rxd, input, 1, asynchronous serial line; idle high.
REQ-007 Port rx_data_ready, output, 1, one-clk pulse when rx_data holds a new valid byte.
REQ-008 Port rx_data, output, 8, last correctly framed byte, LSB received first.
REQ-009 Port rx_frame_error, output, 1, one-clk pulse when the stop bit is sampled low.
REQ-010 Port rx_idle, output, 1, high while the line has been high for at least 2*Oversampling ticks.
REQ-011 Port rx_endofpacket, output, 1, one-clk pulse on the rising edge of rx_idle.

Function
REQ-012 The tick source SHALL be a free-running oversampling tick at Baud*Oversampling, with enable tied high; all state below advances only on tick cycles.
REQ-013 rxd SHALL pass through a 2-FF synchroniser before any other use.
REQ-014 Filter: 2-bit saturating counter; +1 on tick if sync=1, -1 if sync=0; filtered bit rx_bit goes to 1 at count 3, to 0 at count 0, otherwise holds.
REQ-015 FSM states: IDLE, START, DATA, STOP, BREAK; os_cnt is log2(Oversampling) bits; bit_cnt is 3 bits.
REQ-016 IDLE: on a tick with rx_bit=0 -> START, os_cnt=0.
REQ-017 START: os_cnt increments per tick; at os_cnt=Oversampling/2-1, rx_bit=0 -> DATA, os_cnt=0, bit_cnt=0; rx_bit=1 -> IDLE (false start, no output).
REQ-018 DATA: at os_cnt=Oversampling-1, rx_bit is shifted into the MSB of the shift register (right shift), os_cnt wraps to 0; after the sample with bit_cnt=7 -> STOP, else bit_cnt+1.
REQ-019 STOP: at os_cnt=Oversampling-1: rx_bit=1 -> rx_data loaded from the shift register, rx_data_ready pulses, -> IDLE; rx_bit=0 -> rx_frame_error pulses, rx_data unchanged, -> BREAK.
REQ-020 BREAK: stays until a tick with rx_bit=1, then -> IDLE; a continuous low line yields exactly one rx_frame_error.
REQ-021 rx_data_ready and rx_frame_error are registered and assert in the clk cycle after the sampling tick; they are never high simultaneously.
REQ-022 Gap counter: log2(2*Oversampling)+1 bits; cleared on a tick with rx_bit=0, +1 on a tick with rx_bit=1, saturating at 2*Oversampling; rx_idle = (gap counter == 2*Oversampling).
REQ-023 rx_endofpacket pulses in the cycle the gap counter first reaches saturation after having been cleared.
REQ-024 rx_data is stable between rx_data_ready pulses; there is no backpressure, and an unread byte is overwritten by the next frame.

Reset
REQ-025 On rst_n=0 at a clk edge: synchroniser FFs=1, filter count=3, rx_bit=1, FSM=IDLE, os_cnt=0, bit_cnt=0, shift register=0.
REQ-026 Also on reset: rx_data=0, rx_data_ready=0, rx_frame_error=0, gap counter saturated, rx_idle=1, rx_endofpacket=0 (no pulse after reset).
REQ-027 Reset mid-frame SHALL discard the partial byte with no output pulse; reception resumes on the next falling edge after rst_n=1.

Structure
REQ-028 Shared package uart_pkg holds the FSM state enum, DATA_BITS=8, and the legal Oversampling values.
REQ-029 Exactly one sub-module, the existing BaudTickGen, instantiated with Oversampling passed through.
REQ-030 Target size is 120-400 lines of RTL, with no latches and no combinational outputs.

Verification
REQ-031 Frame 0x55 at 115200, 50 MHz -> one rx_data_ready pulse, rx_data=0x55, no frame error, pulse within 1 bit time after the stop-bit midpoint.
REQ-032 Back-to-back 0xA3 then 0x00 with no gap -> two ready pulses, values 0xA3 then 0x00, rx_idle low between them.
REQ-033 Glitch low for 1 tick period (~54 clk) on an idle line -> no FSM exit from IDLE, no pulses; low for 3 ticks (shorter than half a bit) -> false start, back to IDLE, no pulses.
REQ-034 Byte 0x00 followed by the line held low for 20 bit times -> one rx_frame_error pulse, rx_data unchanged, no ready pulse; line high then 0x7E -> rx_data=0x7E.
REQ-035 rst_n low for 2 clk during bit 4 of 0xFF -> no pulses; next frame 0x3C received correctly.
REQ-036 After frame 0x12, line held high -> exactly one rx_endofpacket pulse 16 ticks after the stop-bit end; none after reset alone.
